// File: rtl/perf_check_monitor.sv
`default_nettype none
// ============================================================================
// Module   : perf_check_monitor
// Purpose  : Store-snooping PASS/FAIL/TIMEOUT verdict with saturating cycle,
//            retire and event counters that freeze when the verdict is taken.
// Revision : 1.0  initial release
// ============================================================================
module perf_check_monitor #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned N_EVT       = 4,
    parameter int unsigned PASS_ADDR   = 100,
    parameter int unsigned PASS_DATA   = 25,
    parameter int unsigned IGNORE_ADDR = 96,
    parameter int unsigned WARMUP      = 2,
    parameter int unsigned TIMEOUT     = 100000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   mem_write_i,
    input  logic [XLEN-1:0]        data_adr_i,
    input  logic [XLEN-1:0]        write_data_i,
    input  logic                   retire_i,
    input  logic [N_EVT-1:0]       evt_i,
    output logic [2:0]             state_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic                   fail_o,
    output logic                   timeout_o,
    output logic [CNT_W-1:0]       cycles_o,
    output logic [CNT_W-1:0]       instrs_o,
    output logic [N_EVT*CNT_W-1:0] evt_cnt_o,
    output logic [XLEN-1:0]        fail_adr_o,
    output logic [XLEN-1:0]        fail_data_o
);

    typedef enum logic [2:0] {
        ST_WARMUP  = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam int unsigned     c_WARM_W      = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [XLEN-1:0] c_PASS_ADDR   = XLEN'(PASS_ADDR);
    localparam logic [XLEN-1:0] c_PASS_DATA   = XLEN'(PASS_DATA);
    localparam logic [XLEN-1:0] c_IGNORE_ADDR = XLEN'(IGNORE_ADDR);
    localparam logic [63:0]     c_TO_LAST     = 64'(TIMEOUT) - 64'd1;

    state_t                state_q, state_d;
    logic [c_WARM_W-1:0]   warm_q, warm_d;
    logic [CNT_W-1:0]      cycles_q, cycles_d;
    logic [CNT_W-1:0]      instrs_q, instrs_d;
    logic [XLEN-1:0]       fadr_q, fadr_d;
    logic [XLEN-1:0]       fdata_q, fdata_d;
    logic                  done_q, pass_q, fail_q, timeout_q;

    logic w_count_en;
    logic w_warm_last;
    logic w_verdict_st;
    logic w_pass_st;
    logic w_to_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign w_count_en   = !clear_i && (state_q == ST_RUN);
    assign w_warm_last  = (WARMUP == 0) || (32'(warm_q) == (WARMUP - 1));
    assign w_verdict_st = mem_write_i && (data_adr_i != c_IGNORE_ADDR);
    assign w_pass_st    = (data_adr_i == c_PASS_ADDR) && (write_data_i == c_PASS_DATA);
    // Compare in 64 bits so a TIMEOUT wider than CNT_W simply never fires.
    assign w_to_hit     = (TIMEOUT != 0) && (64'(cycles_q) == c_TO_LAST);

    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        cycles_d = cycles_q;
        instrs_d = instrs_q;
        fadr_d   = fadr_q;
        fdata_d  = fdata_q;
        if (clear_i) begin
            state_d  = ST_WARMUP;
            warm_d   = '0;
            cycles_d = '0;
            instrs_d = '0;
            fadr_d   = '0;
            fdata_d  = '0;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    if (w_warm_last) begin
                        state_d = ST_RUN;
                        warm_d  = '0;
                    end else begin
                        warm_d  = warm_q + c_WARM_W'(1);
                    end
                end
                ST_RUN: begin
                    // The verdict edge still counts its own cycle and retire.
                    cycles_d = sat_inc(cycles_q, 1'b1);
                    instrs_d = sat_inc(instrs_q, retire_i);
                    if (w_verdict_st) begin
                        if (w_pass_st) begin
                            state_d = ST_PASS;
                        end else begin
                            state_d = ST_FAIL;
                            fadr_d  = data_adr_i;
                            fdata_d = write_data_i;
                        end
                    end else if (w_to_hit) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_WARMUP;
            warm_q    <= '0;
            cycles_q  <= '0;
            instrs_q  <= '0;
            fadr_q    <= '0;
            fdata_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            warm_q    <= warm_d;
            cycles_q  <= cycles_d;
            instrs_q  <= instrs_d;
            fadr_q    <= fadr_d;
            fdata_q   <= fdata_d;
            done_q    <= (state_d == ST_PASS) || (state_d == ST_FAIL) || (state_d == ST_TIMEOUT);
            pass_q    <= (state_d == ST_PASS);
            fail_q    <= (state_d == ST_FAIL);
            timeout_q <= (state_d == ST_TIMEOUT);
        end
    end

    for (genvar k = 0; k < N_EVT; k++) begin : g_evt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clear_i) begin
                cnt_d = '0;
            end else if (w_count_en) begin
                cnt_d = sat_inc(cnt_q, evt_i[k]);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign evt_cnt_o[k*CNT_W +: CNT_W] = cnt_q;
    end

    assign state_o     = state_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_o      = fail_q;
    assign timeout_o   = timeout_q;
    assign cycles_o    = cycles_q;
    assign instrs_o    = instrs_q;
    assign fail_adr_o  = fadr_q;
    assign fail_data_o = fdata_q;

endmodule
`default_nettype wire

// File: tb/tb_perf_check_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_perf_check_monitor
// Purpose  : Three monitor instances (default, TIMEOUT=50, CNT_W=4) sharing
//            one stimulus stream, checked against a per-cycle behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_perf_check_monitor;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear_i = 1'b0;
    logic        mw = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdata = '0;
    logic        ret = 1'b0;
    logic [3:0]  evt = '0;

    logic [2:0]   st_w   [NI];
    logic         done_w [NI];
    logic         pass_w [NI];
    logic         fail_w [NI];
    logic         to_w   [NI];
    logic [31:0]  cyc_w  [NI];
    logic [31:0]  ins_w  [NI];
    logic [127:0] evc_w  [NI];
    logic [31:0]  fadr_w [NI];
    logic [31:0]  fdat_w [NI];
    logic [3:0]   cyc2, ins2;
    logic [15:0]  evc2;

    assign cyc_w[2] = {28'd0, cyc2};
    assign ins_w[2] = {28'd0, ins2};
    assign evc_w[2] = {112'd0, evc2};

    always #5 clk = ~clk;

    perf_check_monitor u_dut0 (
        .clk(clk), .reset(reset), .clear_i(clear_i), .mem_write_i(mw), .data_adr_i(adr),
        .write_data_i(wdata), .retire_i(ret), .evt_i(evt), .state_o(st_w[0]), .done_o(done_w[0]),
        .pass_o(pass_w[0]), .fail_o(fail_w[0]), .timeout_o(to_w[0]), .cycles_o(cyc_w[0]),
        .instrs_o(ins_w[0]), .evt_cnt_o(evc_w[0]), .fail_adr_o(fadr_w[0]), .fail_data_o(fdat_w[0])
    );

    perf_check_monitor #(.TIMEOUT(50)) u_dut1 (
        .clk(clk), .reset(reset), .clear_i(clear_i), .mem_write_i(mw), .data_adr_i(adr),
        .write_data_i(wdata), .retire_i(ret), .evt_i(evt), .state_o(st_w[1]), .done_o(done_w[1]),
        .pass_o(pass_w[1]), .fail_o(fail_w[1]), .timeout_o(to_w[1]), .cycles_o(cyc_w[1]),
        .instrs_o(ins_w[1]), .evt_cnt_o(evc_w[1]), .fail_adr_o(fadr_w[1]), .fail_data_o(fdat_w[1])
    );

    perf_check_monitor #(.CNT_W(4)) u_dut2 (
        .clk(clk), .reset(reset), .clear_i(clear_i), .mem_write_i(mw), .data_adr_i(adr),
        .write_data_i(wdata), .retire_i(ret), .evt_i(evt), .state_o(st_w[2]), .done_o(done_w[2]),
        .pass_o(pass_w[2]), .fail_o(fail_w[2]), .timeout_o(to_w[2]), .cycles_o(cyc2),
        .instrs_o(ins2), .evt_cnt_o(evc2), .fail_adr_o(fadr_w[2]), .fail_data_o(fdat_w[2])
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: 0 warmup, 1 run, 2 pass, 3 fail, 4 timeout.
    int          m_state [NI];
    int          m_warm  [NI];
    longint      m_cyc   [NI];
    longint      m_ins   [NI];
    longint      m_evt   [NI][4];
    logic [31:0] m_fadr  [NI];
    logic [31:0] m_fdat  [NI];
    longint      m_max   [NI] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    longint      m_to    [NI] = '{64'd100000, 64'd50, 64'd100000};

    task automatic model_reset(input int i);
        m_state[i] = 0;
        m_warm[i]  = 0;
        m_cyc[i]   = 0;
        m_ins[i]   = 0;
        for (int k = 0; k < 4; k++) m_evt[i][k] = 0;
        m_fadr[i]  = '0;
        m_fdat[i]  = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            if (!reset || clear_i) begin
                model_reset(i);
            end else if (m_state[i] == 0) begin
                m_warm[i]++;
                if (m_warm[i] >= 2) m_state[i] = 1;
            end else if (m_state[i] == 1) begin
                if (m_cyc[i] < m_max[i]) m_cyc[i]++;
                if (ret && m_ins[i] < m_max[i]) m_ins[i]++;
                for (int k = 0; k < 4; k++)
                    if (evt[k] && m_evt[i][k] < m_max[i]) m_evt[i][k]++;
                if (mw && adr != 32'd96) begin
                    if (adr == 32'd100 && wdata == 32'd25) begin
                        m_state[i] = 2;
                    end else begin
                        m_state[i] = 3;
                        m_fadr[i]  = adr;
                        m_fdat[i]  = wdata;
                    end
                end else if (m_to[i] != 0 && m_cyc[i] == m_to[i]) begin
                    m_state[i] = 4;
                end
            end
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic r, input logic [3:0] e);
        mw = w; adr = a; wdata = d; ret = r; evt = e;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; clear_i = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0);
        for (int i = 0; i < NI; i++) model_reset(i);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, '0, '0, 1'b0, '0);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) model_reset(i);
        n_checks++; if (st_w[0] !== 3'd0) $display("FAIL reset_state: got %0d want 0", st_w[0]); else n_pass++;
        n_checks++; if ({done_w[0], pass_w[0], fail_w[0], to_w[0]} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {done_w[0], pass_w[0], fail_w[0], to_w[0]}); else n_pass++;
        n_checks++; if ({cyc_w[0], ins_w[0], evc_w[0], fadr_w[0], fdat_w[0]} !== '0) $display("FAIL reset_counters: cycles %0d instrs %0d not all zero", cyc_w[0], ins_w[0]); else n_pass++;
    endtask

    task automatic test_pass_basic();
        do_reset();
        cycle();
        n_checks++; if (st_w[0] !== 3'd0) $display("FAIL warmup_edge1: got %0d want 0", st_w[0]); else n_pass++;
        cycle();
        n_checks++; if (st_w[0] !== 3'd1) $display("FAIL warmup_edge2: got %0d want 1", st_w[0]); else n_pass++;
        drive(1'b0, '0, '0, 1'b1, '0);
        for (int c = 0; c < 10; c++) cycle();
        drive(1'b1, 32'd100, 32'd25, 1'b1, '0);
        cycle();
        n_checks++; if (st_w[0] !== 3'd2) $display("FAIL pass_state: got %0d want 2", st_w[0]); else n_pass++;
        n_checks++; if ({done_w[0], pass_w[0], fail_w[0], to_w[0]} !== 4'b1100) $display("FAIL pass_flags: got %b want 1100", {done_w[0], pass_w[0], fail_w[0], to_w[0]}); else n_pass++;
        n_checks++; if (cyc_w[0] !== 32'd11) $display("FAIL pass_cycles: got %0d want 11", cyc_w[0]); else n_pass++;
        n_checks++; if (ins_w[0] !== 32'd11) $display("FAIL pass_instrs: got %0d want 11", ins_w[0]); else n_pass++;
        drive(1'b1, 32'd4, 32'd1, 1'b1, 4'hF);
        cycle(); cycle();
        n_checks++; if ({st_w[0], cyc_w[0], ins_w[0], evc_w[0]} !== {3'd2, 32'd11, 32'd11, 128'd0}) $display("FAIL pass_frozen: state %0d cycles %0d instrs %0d want 2/11/11", st_w[0], cyc_w[0], ins_w[0]); else n_pass++;
    endtask

    task automatic test_fail_capture();
        logic [31:0] snap;
        do_reset();
        cycle(); cycle();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, '0, '0, 1'($urandom_range(0, 1)), 4'($urandom));
            cycle();
        end
        drive(1'b1, 32'd96, 32'd7, 1'b1, '0);
        cycle();
        n_checks++; if (st_w[0] !== 3'd1 || done_w[0] !== 1'b0) $display("FAIL ignore_store: state %0d done %0d want 1/0", st_w[0], done_w[0]); else n_pass++;
        drive(1'b1, 32'd100, 32'd24, 1'b1, '0);
        cycle();
        n_checks++; if ({st_w[0], done_w[0], fail_w[0], pass_w[0]} !== {3'd3, 3'b110}) $display("FAIL fail_state: state %0d done %0d fail %0d pass %0d", st_w[0], done_w[0], fail_w[0], pass_w[0]); else n_pass++;
        n_checks++; if (fadr_w[0] !== 32'd100 || fdat_w[0] !== 32'd24) $display("FAIL fail_capture: got %0d/%0d want 100/24", fadr_w[0], fdat_w[0]); else n_pass++;
        n_checks++; if (cyc_w[0] !== 32'd7 || ins_w[0] !== 32'(m_ins[0])) $display("FAIL fail_counts: got %0d/%0d want 7/%0d", cyc_w[0], ins_w[0], m_ins[0]); else n_pass++;
        snap = cyc_w[0];
        drive(1'b1, 32'd100, 32'd25, 1'b1, 4'hF);
        for (int c = 0; c < 5; c++) cycle();
        n_checks++; if (st_w[0] !== 3'd3 || cyc_w[0] !== snap || fadr_w[0] !== 32'd100) $display("FAIL fail_frozen: state %0d cycles %0d want 3/%0d", st_w[0], cyc_w[0], snap); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        cycle(); cycle();
        drive(1'b0, '0, '0, 1'b1, '0);
        for (int c = 0; c < 49; c++) cycle();
        n_checks++; if (st_w[1] !== 3'd1 || cyc_w[1] !== 32'd49) $display("FAIL timeout_early: state %0d cycles %0d want 1/49", st_w[1], cyc_w[1]); else n_pass++;
        cycle();
        n_checks++; if ({st_w[1], done_w[1], to_w[1], pass_w[1]} !== {3'd4, 3'b110}) $display("FAIL timeout_state: state %0d done %0d timeout %0d", st_w[1], done_w[1], to_w[1]); else n_pass++;
        n_checks++; if (cyc_w[1] !== 32'd50) $display("FAIL timeout_cycles: got %0d want 50", cyc_w[1]); else n_pass++;
        do_reset();
        cycle(); cycle();
        drive(1'b0, '0, '0, 1'b1, '0);
        for (int c = 0; c < 49; c++) cycle();
        drive(1'b1, 32'd100, 32'd25, 1'b1, '0);
        cycle();
        n_checks++; if ({st_w[1], pass_w[1], to_w[1]} !== {3'd2, 2'b10}) $display("FAIL timeout_vs_pass: state %0d pass %0d timeout %0d want 2/1/0", st_w[1], pass_w[1], to_w[1]); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        cycle(); cycle();
        drive(1'b0, '0, '0, 1'b1, 4'b0100);
        for (int c = 0; c < 20; c++) cycle();
        n_checks++; if (evc_w[2][11:8] !== 4'd15) $display("FAIL sat_evt2: got %0d want 15", evc_w[2][11:8]); else n_pass++;
        n_checks++; if ({evc_w[2][15:12], evc_w[2][7:0]} !== 12'd0) $display("FAIL sat_other_evts: got %h want 000", {evc_w[2][15:12], evc_w[2][7:0]}); else n_pass++;
        n_checks++; if (cyc_w[2] !== 32'd15 || ins_w[2] !== 32'd15) $display("FAIL sat_cycles: got %0d/%0d want 15/15", cyc_w[2], ins_w[2]); else n_pass++;
        n_checks++; if (evc_w[0][95:64] !== 32'd20) $display("FAIL wide_evt2: got %0d want 20", evc_w[0][95:64]); else n_pass++;
    endtask

    task automatic test_async_reset_and_clear();
        do_reset();
        cycle(); cycle();
        drive(1'b0, '0, '0, 1'b1, 4'hF);
        for (int c = 0; c < 6; c++) cycle();
        reset = 1'b0;
        #2;
        for (int i = 0; i < NI; i++) model_reset(i);
        n_checks++; if (st_w[0] !== 3'd0 || cyc_w[0] !== 32'd0 || ins_w[0] !== 32'd0 || evc_w[0] !== 128'd0) $display("FAIL async_reset: state %0d cycles %0d instrs %0d want all 0", st_w[0], cyc_w[0], ins_w[0]); else n_pass++;
        do_reset();
        cycle(); cycle();
        for (int c = 0; c < 3; c++) cycle();
        drive(1'b1, 32'd100, 32'd25, 1'b1, '0);
        cycle();
        n_checks++; if (st_w[0] !== 3'd2) $display("FAIL clear_pre_pass: got %0d want 2", st_w[0]); else n_pass++;
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        n_checks++; if ({st_w[0], done_w[0], pass_w[0], cyc_w[0], ins_w[0]} !== '0) $display("FAIL clear_zero: state %0d pass %0d cycles %0d instrs %0d want 0", st_w[0], pass_w[0], cyc_w[0], ins_w[0]); else n_pass++;
        drive(1'b0, '0, '0, 1'b0, '0);
        cycle(); cycle();
        drive(1'b1, 32'd100, 32'd25, 1'b0, '0);
        cycle();
        n_checks++; if ({st_w[0], pass_w[0], cyc_w[0], ins_w[0]} !== {3'd2, 1'b1, 32'd1, 32'd0}) $display("FAIL clear_rerun: state %0d cycles %0d instrs %0d want 2/1/0", st_w[0], cyc_w[0], ins_w[0]); else n_pass++;
    endtask

    task automatic test_warmup_store();
        do_reset();
        drive(1'b1, 32'd100, 32'd25, 1'b1, 4'hF);
        cycle(); cycle();
        n_checks++; if (st_w[0] !== 3'd1 || done_w[0] !== 1'b0 || cyc_w[0] !== 32'd0) $display("FAIL warmup_store: state %0d done %0d cycles %0d want 1/0/0", st_w[0], done_w[0], cyc_w[0]); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic        ok;
        int          sel;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            sel = $urandom_range(0, 9);
            mw  = ($urandom_range(0, 99) < 4);
            ret = 1'($urandom_range(0, 1));
            evt = 4'($urandom);
            if (sel < 4)       begin adr = 32'd96;  wdata = $urandom; end
            else if (sel < 7)  begin adr = 32'd100; wdata = 32'd25; end
            else if (sel == 7) begin adr = 32'd100; wdata = 32'($urandom_range(20, 30)); end
            else               begin adr = {$urandom_range(0, 255), 2'b00}; wdata = $urandom; end
            clear_i = ($urandom_range(0, 199) == 0) ||
                      (m_state[0] >= 2 && m_state[1] >= 2 && m_state[2] >= 2);
            cycle();
            for (int i = 0; i < NI; i++) begin
                n_checks++; if (st_w[i] !== 3'(m_state[i])) $display("FAIL rnd_state[%0d] c%0d: got %0d want %0d", i, c, st_w[i], m_state[i]); else n_pass++;
                n_checks++; if ({done_w[i], pass_w[i], fail_w[i], to_w[i]} !== {m_state[i] >= 2, m_state[i] == 2, m_state[i] == 3, m_state[i] == 4}) $display("FAIL rnd_flags[%0d] c%0d: got %b for state %0d", i, c, {done_w[i], pass_w[i], fail_w[i], to_w[i]}, m_state[i]); else n_pass++;
                n_checks++; if (cyc_w[i] !== 32'(m_cyc[i]) || ins_w[i] !== 32'(m_ins[i])) $display("FAIL rnd_counts[%0d] c%0d: got %0d/%0d want %0d/%0d", i, c, cyc_w[i], ins_w[i], m_cyc[i], m_ins[i]); else n_pass++;
                ok = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    got = (i == 2) ? 32'(evc_w[2][k*4 +: 4]) : evc_w[i][k*32 +: 32];
                    if (got !== 32'(m_evt[i][k])) ok = 1'b0;
                end
                n_checks++; if (!ok) $display("FAIL rnd_evt[%0d] c%0d: got %h want %0d %0d %0d %0d", i, c, evc_w[i], m_evt[i][0], m_evt[i][1], m_evt[i][2], m_evt[i][3]); else n_pass++;
                n_checks++; if (fadr_w[i] !== m_fadr[i] || fdat_w[i] !== m_fdat[i]) $display("FAIL rnd_capture[%0d] c%0d: got %h/%h want %h/%h", i, c, fadr_w[i], fdat_w[i], m_fadr[i], m_fdat[i]); else n_pass++;
            end
        end
        clear_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass_basic();
        test_fail_capture();
        test_timeout();
        test_saturation();
        test_async_reset_and_clear();
        test_warmup_store();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
